// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Latency: clock inhibit for INHIBIT_TICKS ticks, then frame paced by device clock; done/err one tick after release/abort.
// Backpressure: tx_ready high only in IDLE, tx_valid ignored while busy. Optional: `define PS2_TX_RETRY_EN for 2 retries.
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 1600,
    parameter int TIMEOUT_TICKS = 32000,
    parameter int FILTER_LEN    = 3
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAXT = (TIMEOUT_TICKS > INHIBIT_TICKS) ? TIMEOUT_TICKS : INHIBIT_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int FW   = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_REL, S_ERROR
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, data_filt, clk_filt_d;
    logic [FW-1:0] clk_fcnt, data_fcnt;
    logic          fall;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] tick_cnt;
    logic          timeout;
    logic          last_try;

`ifdef PS2_TX_RETRY_EN
    logic [7:0]    tx_byte;
    logic [1:0]    retry_cnt;
    assign last_try = (retry_cnt == 2'd2);
`else
    assign last_try = 1'b1;
`endif

    assign tx_ready   = (state == S_IDLE);
    assign rx_inhibit = (state != S_IDLE);
    assign fall       = clk_filt_d & ~clk_filt;
    assign timeout    = (tick_cnt == CW'(TIMEOUT_TICKS - 1));

    // Two-stage synchronisers on both pins, idle-high after reset
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else if (clk_en) begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Glitch filter: a new level is accepted after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            clk_filt   <= 1'b1;
            data_filt  <= 1'b1;
            clk_filt_d <= 1'b1;
            clk_fcnt   <= '0;
            data_fcnt  <= '0;
        end else if (clk_en) begin
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end
            if (data_sync[1] == data_filt) begin
                data_fcnt <= '0;
            end else if (data_fcnt == FW'(FILTER_LEN - 1)) begin
                data_filt <= data_sync[1];
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + 1'b1;
            end
        end
    end

    // Transmit FSM; line enables and status pulses are registered with the state they belong to
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            tick_cnt    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            tx_byte     <= '0;
            retry_cnt   <= '0;
`endif
        end else if (clk_en) begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg      <= {1'b1, ~^tx_data, tx_data};
                        tick_cnt   <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        tx_byte    <= tx_data;
                        retry_cnt  <= '0;
`endif
                    end
                end
                S_INHIBIT: begin
                    if (tick_cnt == CW'(INHIBIT_TICKS - 1)) begin
                        tick_cnt    <= '0;
                        ps2_data_oe <= 1'b1;    // start bit
                        state       <= S_REQ;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    tick_cnt   <= '0;
                    bit_cnt    <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (fall) begin
                        // open-drain: drive low for a 0 bit, release for a 1 bit
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b0, shreg[9:1]};
                        bit_cnt     <= bit_cnt + 1'b1;
                        tick_cnt    <= '0;
                        if (bit_cnt == 4'd9) state <= S_ACK;
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= last_try;
                        state       <= S_ERROR;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (fall && !data_filt) begin
                        tick_cnt <= '0;
                        state    <= S_WAIT_REL;
                    end else if (fall || timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= last_try;
                        state       <= S_ERROR;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (clk_filt && data_filt) begin
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end else if (fall) begin
                        tick_cnt <= '0;
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= last_try;
                        state       <= S_ERROR;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_ERROR: begin
                    ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                    if (!last_try) begin
                        shreg      <= {1'b1, ~^tx_byte, tx_byte};
                        retry_cnt  <= retry_cnt + 1'b1;
                        tick_cnt   <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end else begin
                        ps2_clk_oe <= 1'b0;
                        state      <= S_IDLE;
                    end
`else
                    ps2_clk_oe <= 1'b0;
                    state      <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
// Latency: device clock half-period HALF ticks; inhibit/timeout measured in clk_en ticks.
// Backpressure: tx_valid pulsed or held; device model waits on the host request with bounded loops.
module tb_ps2_host_tx;
    localparam int INH  = 1600;
    localparam int TO   = 2000;
    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       nRESET = 1'b1;
    logic       clk_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int total = 0;
    int pass_cnt = 0;
    int done_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int ready_ticks = 0;
    logic [1:0] err_oe = 2'b00;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TO), .FILTER_LEN(3)) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    // pulse/ready monitor sampled mid-cycle
    always @(negedge clk) begin
        if (tx_done) done_seen++;
        if (tx_err) begin
            err_seen++;
            err_oe = {ps2_clk_oe, ps2_data_oe};
        end
        if (tx_done && tx_err) both_seen++;
        if (tx_ready) ready_ticks++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Device: waits for the request, clocks 10 bits sampling at the end of each high phase, then ACK cycle
    task automatic dev_frame(input logic ack_bit, input int stop_after, input logic glitch,
                             output logic [9:0] got);
        int w;
        got = '0;
        w = 0;
        while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && w < INH + 200) begin
            tick();
            w++;
        end
        total++;
        if (w >= INH + 200 || ps2_data_in !== 1'b0) begin
            $display("FAIL start: waited=%0d data_pin=%b, want request seen and data_pin=0", w, ps2_data_in);
            return;
        end
        pass_cnt++;
        repeat (25) tick();
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            if (i + 1 == stop_after) begin
                repeat (10) tick();
                return;
            end
            repeat (HALF) tick();
            dev_clk = 1'b1;
            if (glitch && i == 3) begin
                repeat (5) tick();
                dev_clk = 1'b0;
                tick();
                dev_clk = 1'b1;
                repeat (HALF - 7) tick();
            end else begin
                repeat (HALF - 1) tick();
            end
            got[i] = ps2_data_in;
            tick();
        end
        dev_data = ack_bit;
        repeat (10) tick();
        dev_clk = 1'b0;
        repeat (HALF) tick();
        dev_clk = 1'b1;
        repeat (10) tick();
        dev_data = 1'b1;
    endtask

    task automatic test_reset();
        logic bad;
        #1 nRESET = 1'b0;
        #2;
        total++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx_err !== 1'b0 || rx_inhibit !== 1'b0 ||
            ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL reset_state: ready=%b done=%b err=%b inhibit=%b clk_oe=%b data_oe=%b, want 1 0 0 0 0 0",
                     tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe);
        else pass_cnt++;
        repeat (3) tick();
        nRESET = 1'b1;
        repeat (5) tick();
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dev_clk = 1'b0;
            dev_data = 1'b0;
            for (int j = 0; j < 2 * HALF; j++) begin
                if (j == HALF) begin
                    dev_clk = 1'b1;
                    dev_data = 1'b1;
                end
                tick();
                if (rx_inhibit !== 1'b0 || tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
                    bad = 1'b1;
            end
        end
        total++;
        if (bad !== 1'b0 || done_seen != 0 || err_seen != 0)
            $display("FAIL idle_traffic: disturbed=%b done=%0d err=%0d, want 0 0 0", bad, done_seen, err_seen);
        else pass_cnt++;
    endtask

    task automatic test_send(input logic [7:0] d, input logic par, input logic hold);
        logic [9:0] got;
        int n, d0, e0, exp_n;
        d0 = done_seen;
        e0 = err_seen;
        tx_data = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        total++;
        if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1 || rx_inhibit !== 1'b1 || ps2_data_oe !== 1'b0)
            $display("FAIL accept_%h: ready=%b clk_oe=%b inhibit=%b data_oe=%b, want 0 1 1 0",
                     d, tx_ready, ps2_clk_oe, rx_inhibit, ps2_data_oe);
        else pass_cnt++;
        exp_n = INH;
        if (hold) begin
            repeat (5) tick();
            clk_en = 1'b0;
            repeat (50) tick();
            total++;
            if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b0)
                $display("FAIL hold_%h: clk_oe=%b data_oe=%b ready=%b, want 1 0 0", d, ps2_clk_oe, ps2_data_oe, tx_ready);
            else pass_cnt++;
            clk_en = 1'b1;
            exp_n = INH - 5;
        end
        n = 0;
        while (ps2_data_oe !== 1'b1 && n < INH + 50) begin
            tick();
            n++;
        end
        total++;
        if (n != exp_n || ps2_clk_oe !== 1'b1)
            $display("FAIL inhibit_len_%h: ticks=%0d clk_oe=%b, want %0d and 1", d, n, ps2_clk_oe, exp_n);
        else pass_cnt++;
        dev_frame(1'b0, 99, 1'b0, got);
        total++;
        if (got !== {1'b1, par, d})
            $display("FAIL frame_%h: got=%b, want %b", d, got, {1'b1, par, d});
        else pass_cnt++;
        repeat (30) tick();
        total++;
        if (done_seen - d0 != 1 || err_seen - e0 != 0 || tx_ready !== 1'b1 ||
            ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL done_%h: done=%0d err=%0d ready=%b clk_oe=%b data_oe=%b, want 1 0 1 0 0",
                     d, done_seen - d0, err_seen - e0, tx_ready, ps2_clk_oe, ps2_data_oe);
        else pass_cnt++;
    endtask

    task automatic test_nack();
        logic [9:0] got;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        tx_data = 8'hED;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_frame(1'b1, 99, 1'b0, got);
            total++;
            if (got !== 10'b1_1_1110_1101)
                $display("FAIL nack_frame%0d: got=%b, want %b", a, got, 10'b1_1_1110_1101);
            else pass_cnt++;
        end
        repeat (30) tick();
        total++;
        if (err_seen - e0 != 1 || done_seen - d0 != 0 || err_oe !== 2'b00 || tx_ready !== 1'b1)
            $display("FAIL nack: err=%0d done=%0d oe_at_err=%b ready=%b, want 1 0 00 1",
                     err_seen - e0, done_seen - d0, err_oe, tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k, w, phases;
        logic prev, inh_ok;
        tx_data = 8'h01;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        phases = (ps2_clk_oe === 1'b1) ? 1 : 0;
        prev = ps2_clk_oe;
        inh_ok = 1'b1;
        k = 0;
        w = 0;
        while (tx_err !== 1'b1 && w < 3 * (INH + TO) + 500) begin
            tick();
            w++;
            k++;
            if (ps2_clk_oe === 1'b1 && prev === 1'b0) phases++;
            if (ps2_clk_oe === 1'b0 && prev === 1'b1) k = 0;
            prev = ps2_clk_oe;
            if (rx_inhibit !== 1'b1) inh_ok = 1'b0;
        end
        total++;
        if (tx_err !== 1'b1 || k != TO)
            $display("FAIL timeout_len: err=%b ticks_after_release=%0d, want 1 and %0d", tx_err, k, TO);
        else pass_cnt++;
        total++;
        if (phases != ATTEMPTS || inh_ok !== 1'b1)
            $display("FAIL timeout_phases: phases=%0d inhibit_held=%b, want %0d and 1", phases, inh_ok, ATTEMPTS);
        else pass_cnt++;
        repeat (3) tick();
        total++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL timeout_idle: ready=%b clk_oe=%b data_oe=%b, want 1 0 0", tx_ready, ps2_clk_oe, ps2_data_oe);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        dev_frame(1'b0, 4, 1'b0, got);
        total++;
        if (ps2_data_oe !== 1'b1)
            $display("FAIL pre_reset: data_oe=%b, want 1 (D3 of A5 is 0)", ps2_data_oe);
        else pass_cnt++;
        #2 nRESET = 1'b0;
        #1;
        total++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || rx_inhibit !== 1'b0)
            $display("FAIL async_reset: clk_oe=%b data_oe=%b ready=%b inhibit=%b, want 0 0 1 0",
                     ps2_clk_oe, ps2_data_oe, tx_ready, rx_inhibit);
        else pass_cnt++;
        dev_clk = 1'b1;
        tick();
        tick();
        nRESET = 1'b1;
        repeat (10) tick();
        total++;
        if (done_seen != d0 || err_seen != e0 || ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1)
            $display("FAIL discard: done=%0d err=%0d clk_oe=%b ready=%b, want 0 0 0 1",
                     done_seen - d0, err_seen - e0, ps2_clk_oe, tx_ready);
        else pass_cnt++;
        test_send(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        int d0, e0, r0;
        d0 = done_seen;
        e0 = err_seen;
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        tick();
        r0 = ready_ticks;
        dev_frame(1'b0, 99, 1'b1, got);
        total++;
        if (got !== 10'b1_0_1111_0100)
            $display("FAIL b2b_frame1: got=%b, want %b", got, 10'b1_0_1111_0100);
        else pass_cnt++;
        dev_frame(1'b0, 99, 1'b0, got);
        total++;
        if (got !== 10'b1_0_1111_0100)
            $display("FAIL b2b_frame2: got=%b, want %b", got, 10'b1_0_1111_0100);
        else pass_cnt++;
        total++;
        if (ready_ticks - r0 != 1)
            $display("FAIL b2b_ready_gap: ready_ticks=%0d, want 1", ready_ticks - r0);
        else pass_cnt++;
        tx_valid = 1'b0;
        repeat (30) tick();
        total++;
        if (done_seen - d0 != 2 || err_seen - e0 != 0 || tx_ready !== 1'b1 ||
            ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL b2b_done: done=%0d err=%0d ready=%b clk_oe=%b data_oe=%b, want 2 0 1 0 0",
                     done_seen - d0, err_seen - e0, tx_ready, ps2_clk_oe, ps2_data_oe);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 1'b1, 1'b0);
        test_send(8'h01, 1'b0, 1'b1);
        test_send(8'h00, 1'b1, 1'b0);
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (both_seen != 0)
            $display("FAIL exclusive: done_and_err_together=%0d, want 0", both_seen);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
